// File: rtl/axis_packet_rr_arbiter.sv
// Packet-atomic round-robin merge of NUM_INPUTS AXI-Stream sources onto one output.
// Data, valid and ready pass combinationally; only the grant state is registered.
module axis_packet_rr_arbiter #(
  parameter int NUM_INPUTS = 4,
  parameter int DATA_WIDTH = 32,
  parameter bit HAS_KEEP   = 1'b1,
  parameter bit HAS_LAST   = 1'b1,
  localparam int IDX_WIDTH  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1,
  localparam int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_INPUTS*KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [NUM_INPUTS-1:0]            s_axis_tlast,
  input  logic [NUM_INPUTS-1:0]            s_axis_tvalid,
  output logic [NUM_INPUTS-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]            m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]            m_axis_tkeep,
  output logic                             m_axis_tlast,
  output logic [IDX_WIDTH-1:0]             m_axis_tid,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready
);

  localparam int NUM_SLOTS = 1 << IDX_WIDTH;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_INPUTS - 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t               state_reg;
  logic [IDX_WIDTH-1:0] lock_idx_reg;
  logic [IDX_WIDTH-1:0] last_idx_reg;

  // Streams padded to a power-of-two slot count so any index value selects a defined (zero) entry.
  logic [DATA_WIDTH-1:0] data_arr [NUM_SLOTS];
  logic [KEEP_WIDTH-1:0] keep_arr [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]  valid_pad;
  logic [NUM_SLOTS-1:0]  last_pad;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      if (gi < NUM_INPUTS) begin : g_used
        assign data_arr[gi]  = s_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
        assign keep_arr[gi]  = s_axis_tkeep[gi*KEEP_WIDTH +: KEEP_WIDTH];
        assign valid_pad[gi] = s_axis_tvalid[gi];
        assign last_pad[gi]  = s_axis_tlast[gi];
      end else begin : g_unused
        assign data_arr[gi]  = '0;
        assign keep_arr[gi]  = '0;
        assign valid_pad[gi] = 1'b0;
        assign last_pad[gi]  = 1'b0;
      end
    end
  endgenerate

  // Rotating priority search starting just after the last stream to finish a packet.
  logic [IDX_WIDTH-1:0] rr_idx;
  logic [IDX_WIDTH-1:0] cand;
  logic                 rr_found;

  always_comb begin
    rr_idx   = '0;
    rr_found = 1'b0;
    cand     = last_idx_reg;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      cand = (cand == LAST_IDX) ? '0 : cand + 1'b1;
      if (!rr_found && valid_pad[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
  end

  logic                 locked;
  logic                 any_valid;
  logic                 out_en;
  logic [IDX_WIDTH-1:0] sel;
  logic                 eff_last;
  logic                 xfer;

  assign locked    = (state_reg == LOCKED);
  assign any_valid = |s_axis_tvalid;
  assign out_en    = locked | any_valid;
  assign sel       = locked ? lock_idx_reg : rr_idx;
  assign eff_last  = HAS_LAST ? last_pad[sel] : 1'b1;

  assign m_axis_tvalid = ~rst & (locked ? valid_pad[lock_idx_reg] : any_valid);
  assign m_axis_tdata  = out_en ? data_arr[sel] : '0;
  assign m_axis_tkeep  = (HAS_KEEP && out_en) ? keep_arr[sel] : '0;
  assign m_axis_tlast  = (HAS_LAST && out_en) ? last_pad[sel] : 1'b0;
  assign m_axis_tid    = out_en ? sel : '0;
  assign xfer          = m_axis_tvalid & m_axis_tready;

  generate
    for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_ready
      assign s_axis_tready[gi] = ~rst & m_axis_tready & out_en & (sel == IDX_WIDTH'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      lock_idx_reg <= '0;
      last_idx_reg <= LAST_IDX;
    end else if (state_reg == IDLE) begin
      if (xfer) begin
        if (eff_last) begin
          last_idx_reg <= sel;
        end else begin
          state_reg    <= LOCKED;
          lock_idx_reg <= sel;
        end
      end
    end else begin
      // A valid gap on the locked stream just stalls; only a final beat releases.
      if (xfer && eff_last) begin
        state_reg    <= IDLE;
        last_idx_reg <= lock_idx_reg;
      end
    end
  end

endmodule

// File: tb/tb_axis_packet_rr_arbiter.sv
// Directed bench: a 4-input and a 3-input arbiter driven with hand-computed grant sequences.
module tb_axis_packet_rr_arbiter;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  // 4-input instance
  logic [127:0] s_tdata4;
  logic [15:0]  s_tkeep4;
  logic [3:0]   s_tlast4, s_tvalid4, s_tready4;
  logic [31:0]  m_tdata4;
  logic [3:0]   m_tkeep4;
  logic         m_tlast4, m_tvalid4, m_tready4;
  logic [1:0]   m_tid4;

  // 3-input instance
  logic [95:0]  s_tdata3;
  logic [11:0]  s_tkeep3;
  logic [2:0]   s_tlast3, s_tvalid3, s_tready3;
  logic [31:0]  m_tdata3;
  logic [3:0]   m_tkeep3;
  logic         m_tlast3, m_tvalid3, m_tready3;
  logic [1:0]   m_tid3;

  axis_packet_rr_arbiter #(.NUM_INPUTS(4), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata4), .s_axis_tkeep(s_tkeep4), .s_axis_tlast(s_tlast4),
    .s_axis_tvalid(s_tvalid4), .s_axis_tready(s_tready4),
    .m_axis_tdata(m_tdata4), .m_axis_tkeep(m_tkeep4), .m_axis_tlast(m_tlast4),
    .m_axis_tid(m_tid4), .m_axis_tvalid(m_tvalid4), .m_axis_tready(m_tready4)
  );

  axis_packet_rr_arbiter #(.NUM_INPUTS(3), .DATA_WIDTH(32)) dut3 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata3), .s_axis_tkeep(s_tkeep3), .s_axis_tlast(s_tlast3),
    .s_axis_tvalid(s_tvalid3), .s_axis_tready(s_tready3),
    .m_axis_tdata(m_tdata3), .m_axis_tkeep(m_tkeep3), .m_axis_tlast(m_tlast3),
    .m_axis_tid(m_tid3), .m_axis_tvalid(m_tvalid3), .m_axis_tready(m_tready3)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] data_for(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  // One cycle on the 4-input DUT: sample settled outputs, then let the edge happen.
  task automatic beat4(input string tag, input bit exp_valid, input int exp_tid,
                       input logic [3:0] exp_ready);
    #1;
    $display("[%0t] %s valid=%0b tid=%0d s_ready=%b last=%0b", $time, tag,
             m_tvalid4, m_tid4, s_tready4, m_tlast4);
    check({tag, ".valid"}, 32'(m_tvalid4), 32'(exp_valid));
    check({tag, ".s_ready"}, 32'(s_tready4), 32'(exp_ready));
    if (exp_valid) begin
      check({tag, ".tid"}, 32'(m_tid4), 32'(exp_tid));
      check({tag, ".tdata"}, m_tdata4, data_for(exp_tid));
      check({tag, ".tkeep"}, 32'(m_tkeep4), 32'(exp_tid + 1));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic beat3(input string tag, input int exp_tid);
    #1;
    $display("[%0t] %s valid=%0b tid=%0d s_ready=%b", $time, tag, m_tvalid3, m_tid3, s_tready3);
    check({tag, ".valid"}, 32'(m_tvalid3), 32'd1);
    check({tag, ".tid"}, 32'(m_tid3), 32'(exp_tid));
    check({tag, ".s_ready"}, 32'(s_tready3), 32'(1 << exp_tid));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int seq4 [6] = '{0, 1, 2, 3, 0, 1};
    int seq3 [6] = '{0, 1, 2, 0, 1, 2};

    rst = 1'b1;
    s_tvalid4 = '0; s_tlast4 = '0; m_tready4 = 1'b0;
    s_tvalid3 = '0; s_tlast3 = '0; m_tready3 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_tdata4[i*32 +: 32] = data_for(i);
      s_tkeep4[i*4 +: 4]   = 4'(i + 1);
    end
    for (int i = 0; i < 3; i++) begin
      s_tdata3[i*32 +: 32] = data_for(i);
      s_tkeep3[i*4 +: 4]   = 4'(i + 1);
    end
    @(posedge clk); #1;

    // Outputs held quiet under reset even with everything valid
    s_tvalid4 = 4'hF; s_tlast4 = 4'hF; m_tready4 = 1'b1;
    beat4("reset_hold", 1'b0, 0, 4'b0000);

    // Idle with nothing valid: outputs all zero
    rst = 1'b0; s_tvalid4 = 4'h0;
    #1;
    check("idle.tdata", m_tdata4, 32'h0);
    check("idle.tid", 32'(m_tid4), 32'd0);
    beat4("idle", 1'b0, 0, 4'b0000);

    // One-beat packets on all streams rotate 0,1,2,3,0,1
    s_tvalid4 = 4'hF; s_tlast4 = 4'hF;
    for (int k = 0; k < 6; k++)
      beat4($sformatf("rr%0d", k), 1'b1, seq4[k], 4'(1 << seq4[k]));

    // Stream 2 holds the output for a 3-beat packet, then stream 3 is next
    s_tlast4 = 4'b1011;
    beat4("pkt2_b0", 1'b1, 2, 4'b0100);
    beat4("pkt2_b1", 1'b1, 2, 4'b0100);
    s_tlast4 = 4'hF;
    beat4("pkt2_b2", 1'b1, 2, 4'b0100);
    #1;
    check("pkt2_last", 32'(m_tlast4), 32'd1);
    beat4("after_pkt2", 1'b1, 3, 4'b1000);

    // Locked stream 1 gaps for 2 cycles while stream 0 waits
    s_tvalid4 = 4'b0010; s_tlast4 = 4'b0000;
    beat4("gap_b0", 1'b1, 1, 4'b0010);
    s_tvalid4 = 4'b0001; s_tlast4 = 4'b0001;
    beat4("gap_c0", 1'b0, 0, 4'b0010);
    beat4("gap_c1", 1'b0, 0, 4'b0010);
    s_tvalid4 = 4'b0011; s_tlast4 = 4'b0001;
    beat4("gap_b1", 1'b1, 1, 4'b0010);
    s_tlast4 = 4'b0011;
    beat4("gap_b2", 1'b1, 1, 4'b0010);
    s_tvalid4 = 4'b0001;
    beat4("gap_after", 1'b1, 0, 4'b0001);

    // Set last_idx=2, then stall with stream 3 valid; stream 0 joins on cycle 3
    s_tvalid4 = 4'b0100; s_tlast4 = 4'hF;
    beat4("pre_stall", 1'b1, 2, 4'b0100);
    m_tready4 = 1'b0; s_tvalid4 = 4'b1000;
    beat4("stall_c1", 1'b1, 3, 4'b0000);
    beat4("stall_c2", 1'b1, 3, 4'b0000);
    s_tvalid4 = 4'b1001;
    beat4("stall_c3", 1'b1, 3, 4'b0000);
    beat4("stall_c4", 1'b1, 3, 4'b0000);
    beat4("stall_c5", 1'b1, 3, 4'b0000);
    m_tready4 = 1'b1;
    beat4("stall_go", 1'b1, 3, 4'b1000);
    s_tvalid4 = 4'b0001;
    beat4("stall_next", 1'b1, 0, 4'b0001);

    // Reset after beat 2 of a 4-beat stream-1 packet drops the lock
    s_tvalid4 = 4'b0010; s_tlast4 = 4'b0000;
    beat4("rstpkt_b0", 1'b1, 1, 4'b0010);
    beat4("rstpkt_b1", 1'b1, 1, 4'b0010);
    rst = 1'b1;
    beat4("rstpkt_rst", 1'b0, 0, 4'b0000);
    rst = 1'b0; s_tvalid4 = 4'hF; s_tlast4 = 4'hF;
    beat4("rstpkt_g0", 1'b1, 0, 4'b0001);
    beat4("rstpkt_g1", 1'b1, 1, 4'b0010);

    // Three inputs: wrap skips index 3
    s_tvalid3 = 3'b111; s_tlast3 = 3'b111; m_tready3 = 1'b1;
    for (int k = 0; k < 6; k++)
      beat3($sformatf("n3_rr%0d", k), seq3[k]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axis_packet_rr_arbiter.md
# axis_packet_rr_arbiter

Zero-latency, packet-atomic round-robin arbiter that merges NUM_INPUTS AXI-Stream sources onto one AXI-Stream output. It sits downstream of per-source zero_latency-style FIFOs and feeds a shared consumer, such as a MAC, DMA or a further FIFO. A packet is never interleaved with another once its first beat has transferred. The block adds no pipeline registers: data, valid and ready pass combinationally. Only the arbitration state is registered.

## Interface
- NUM_INPUTS, 4, number of requesting streams (2..16)
- DATA_WIDTH, 32, tdata width per stream (multiple of 8)
- HAS_KEEP, 1, 0: m_axis_tkeep driven all-zero
- HAS_LAST, 1, 0: every beat is treated as a one-beat packet; m_axis_tlast driven 0
- IDX_WIDTH, derived, max(1, $clog2(NUM_INPUTS)); not user-set
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- s_axis_tdata  in  NUM_INPUTS*DATA_WIDTH  stream i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- s_axis_tkeep  in  NUM_INPUTS*DATA_WIDTH/8  stream i at [i*DATA_WIDTH/8 +: DATA_WIDTH/8]
- s_axis_tlast  in  NUM_INPUTS  per-stream last
- s_axis_tvalid  in  NUM_INPUTS  per-stream valid
- s_axis_tready  out  NUM_INPUTS  per-stream ready
- m_axis_tdata  out  DATA_WIDTH  selected stream data
- m_axis_tkeep  out  DATA_WIDTH/8  selected stream keep
- m_axis_tlast  out  1  selected stream last
- m_axis_tid  out  IDX_WIDTH  index of selected stream
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready

## Operation
- Registered state:
  - state ∈ {IDLE, LOCKED}
  - lock_idx (IDX_WIDTH bits)
  - last_idx (IDX_WIDTH bits): the stream that completed the most recent packet
- Selection in IDLE (combinational): sel is the first i with s_axis_tvalid[i]=1, searching (last_idx+1) mod NUM_INPUTS, (last_idx+2) mod NUM_INPUTS, and so on, wrapping. Modulo is over NUM_INPUTS, not 2^IDX_WIDTH.
- If no input is valid: m_axis_tvalid=0, and m_axis_tdata/tkeep/tlast/tid are all driven 0.
- Selection in LOCKED: sel = lock_idx. m_axis_tvalid = s_axis_tvalid[lock_idx]. Other streams are ignored even if valid.
- Outputs: m_axis_* mirror stream sel. s_axis_tready[i] = m_axis_tready & (i==sel) & (state==LOCKED | any_valid). All other readies are 0.
- Transfer: xfer = m_axis_tvalid & m_axis_tready. The effective last is eff_last = HAS_LAST ? s_axis_tlast[sel] : 1.
- IDLE transitions:
  - xfer & eff_last: stay IDLE; last_idx <= sel.
  - xfer & ~eff_last: go to LOCKED; lock_idx <= sel.
  - no xfer: no state change. The grant is not held, so sel may change next cycle if a higher-priority stream becomes valid.
- LOCKED transitions:
  - xfer & eff_last: go to IDLE; last_idx <= lock_idx.
  - otherwise: stay LOCKED. A valid gap on the locked stream stalls the output (m_axis_tvalid=0) and does not release the lock.

## Timing
- Reset (rst=1 at an edge): state=IDLE, last_idx=NUM_INPUTS-1, so stream 0 has top priority after reset. lock_idx=0.
- Outputs are combinational from inputs and state. While rst is held: s_axis_tready=0 and m_axis_tvalid=0, regardless of inputs.
- Reset mid-packet: the lock is dropped. On the first cycle after reset deassertion, arbitration restarts from IDLE with stream 0 highest. Packet repair is the upstream's job.
- Latency: zero cycles, input to output. There is no bubble between packets. A new packet from a different stream may transfer in the cycle right after the previous tlast transfer.
- Throughput: one beat per cycle when the selected stream is valid and m_axis_tready=1.
- Combinational paths:
  - m_axis_tready → s_axis_tready
  - s_axis_tvalid → m_axis_*
- Single-beat packet (tlast on the first beat): no LOCKED cycle is entered.
- NUM_INPUTS not a power of 2: round-robin wrap must skip unused index values.

## Test plan
- Reset then all four streams valid with one-beat packets, m_axis_tready=1 → m_axis_tid sequence 0,1,2,3,0,1 on consecutive cycles with no bubbles.
- Stream 2 sends a 3-beat packet while streams 0, 1 and 3 are continuously valid → tid=2 for 3 consecutive beats. s_axis_tready[0,1,3]=0 throughout. Next grant is tid=3.
- Locked stream 1 drops valid for 2 cycles mid-packet while stream 0 is valid → m_axis_tvalid=0 for those 2 cycles. Stream 1 resumes, then the packet completes. No stream-0 beat is interleaved.
- m_axis_tready=0 for 5 cycles with stream 3 valid in IDLE, and stream 0 becomes valid in cycle 3 (last_idx=2) → tid stays 3, since 3 is searched before 0. When ready rises, one beat transfers from stream 3.
- NUM_INPUTS=3, one-beat packets on all streams → tid sequence 0,1,2,0, with no tid=3 ever appearing.
- rst asserted during a 4-beat packet from stream 1 after beat 2 → after release, all streams valid → first grant is tid=0, state is IDLE.
